clk_gate_ctrl: RTL and testbench



---
 rtl/clk_gate_ctrl.sv | 148 ++++++++++++++
 tb/tb_clk_gate_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// Clock-gate sequencer: wakes a gated datapath clock on request, grants it
// round-robin to one requester at a time and sleeps after an idle timeout.
module clk_gate_ctrl #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned WAKE_CYC = 2,
  parameter int unsigned IDLE_CYC = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] Req,
  input  logic               Test_Mode,
  output logic               Gate_EN,
  output logic [NUM_REQ-1:0] Grant,
  output logic               Busy
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IdxW-1:0]  LastRst  = IdxW'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] WakeLoad = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] IdleLoad = CNT_W'(IDLE_CYC - 1);

  typedef enum logic [2:0] {
    StSleep = 3'd0,
    StWake  = 3'd1,
    StGrant = 3'd2,
    StArb   = 3'd3,
    StIdle  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]    last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               gate_q, gate_d;
  logic               busy_q, busy_d;

  logic               any_req;
  logic               hold;
  logic [IdxW-1:0]    cand_idx;
  logic [IdxW-1:0]    arb_idx;
  logic [NUM_REQ-1:0] arb_onehot;

  assign any_req = |Req;
  assign hold    = |(grant_q & Req);

  // Scan from farthest to nearest so the nearest asserted index after last_q wins.
  always_comb begin
    cand_idx = last_q;
    arb_idx  = last_q;
    for (int i = NUM_REQ; i > 0; i--) begin
      cand_idx = IdxW'((int'(last_q) + i) % int'(NUM_REQ));
      if (Req[cand_idx]) begin
        arb_idx = cand_idx;
      end
    end
  end

  assign arb_onehot = NUM_REQ'(1) << arb_idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = '0;

    unique case (state_q)
      StSleep: begin
        if (any_req) begin
          state_d = StWake;
          cnt_d   = WakeLoad;
        end
      end
      StWake: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (any_req) begin
          state_d = StGrant;
          grant_d = arb_onehot;
          last_d  = arb_idx;
        end else begin
          state_d = StIdle;
          cnt_d   = IdleLoad;
        end
      end
      StGrant: begin
        if (hold) begin
          grant_d = grant_q;
        end else begin
          state_d = StArb;
        end
      end
      StArb: begin
        if (any_req) begin
          state_d = StGrant;
          grant_d = arb_onehot;
          last_d  = arb_idx;
        end else begin
          state_d = StIdle;
          cnt_d   = IdleLoad;
        end
      end
      StIdle: begin
        // A request on the expiry edge still wins over going to sleep.
        if (any_req) begin
          state_d = StGrant;
          grant_d = arb_onehot;
          last_d  = arb_idx;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = StSleep;
        end
      end
      default: begin
        state_d = StSleep;
        cnt_d   = '0;
      end
    endcase

    gate_d = (state_d != StSleep);
    busy_d = (state_d != StSleep);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= StSleep;
      cnt_q   <= '0;
      last_q  <= LastRst;
      grant_q <= '0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
    end
  end

  // Test_Mode is static during scan, so the OR cannot glitch the gate enable.
  assign Gate_EN = gate_q | Test_Mode;
  assign Grant   = grant_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl with NUM_REQ=2, WAKE_CYC=2, IDLE_CYC=4.
// Observed word per cycle is {Gate_EN, Grant[1:0], Busy}.
module tb_clk_gate_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [1:0] Req = 2'b00;
  logic       Test_Mode = 1'b0;
  logic       Gate_EN;
  logic [1:0] Grant;
  logic       Busy;

  int n_vec = 0;
  int n_err = 0;

  clk_gate_ctrl #(
    .NUM_REQ (2),
    .WAKE_CYC(2),
    .IDLE_CYC(4),
    .CNT_W   (4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Req      (Req),
    .Test_Mode(Test_Mode),
    .Gate_EN  (Gate_EN),
    .Grant    (Grant),
    .Busy     (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    Req = 2'b00;
    Test_Mode = 1'b0;
    tick();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    Req = 2'b00;
    Test_Mode = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({Gate_EN, Grant, Busy} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_state: got %b expected %b", {Gate_EN, Grant, Busy}, 4'b0000);
    end
    RST = 1'b1;
    tick();
    n_vec++;
    if ({Gate_EN, Grant, Busy} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_quiet: got %b expected %b", {Gate_EN, Grant, Busy}, 4'b0000);
    end
  endtask

  // Rows are {Req, expected obs after the edge that samples that Req}.
  task automatic test_single();
    logic [5:0] v [13];
    v = '{6'b01_1001, 6'b01_1001, 6'b01_1011, 6'b01_1011, 6'b01_1011, 6'b01_1011,
          6'b00_1001, 6'b00_1001, 6'b00_1001, 6'b00_1001, 6'b00_1001, 6'b00_0000,
          6'b00_0000};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      Req = v[i][5:4];
      tick();
      n_vec++;
      if ({Gate_EN, Grant, Busy} !== v[i][3:0]) begin
        n_err++;
        $display("FAIL single step %0d: got %b expected %b", i + 1, {Gate_EN, Grant, Busy},
                 v[i][3:0]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [5:0] v [12];
    v = '{6'b11_1001, 6'b11_1001, 6'b11_1011, 6'b11_1011, 6'b10_1001, 6'b11_1101,
          6'b11_1101, 6'b01_1001, 6'b11_1011, 6'b11_1011, 6'b10_1001, 6'b11_1101};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      Req = v[i][5:4];
      tick();
      n_vec++;
      if ({Gate_EN, Grant, Busy} !== v[i][3:0]) begin
        n_err++;
        $display("FAIL round_robin step %0d: got %b expected %b", i + 1,
                 {Gate_EN, Grant, Busy}, v[i][3:0]);
      end
    end
  endtask

  task automatic test_late_idle();
    logic [5:0] v [14];
    v = '{6'b01_1001, 6'b01_1001, 6'b01_1011, 6'b01_1011, 6'b01_1011, 6'b01_1011,
          6'b00_1001, 6'b00_1001, 6'b00_1001, 6'b00_1001, 6'b00_1001, 6'b10_1101,
          6'b10_1101, 6'b00_1001};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      Req = v[i][5:4];
      tick();
      n_vec++;
      if ({Gate_EN, Grant, Busy} !== v[i][3:0]) begin
        n_err++;
        $display("FAIL late_idle step %0d: got %b expected %b", i + 1,
                 {Gate_EN, Grant, Busy}, v[i][3:0]);
      end
    end
  endtask

  task automatic test_wake_withdraw();
    logic [5:0] v [8];
    v = '{6'b01_1001, 6'b00_1001, 6'b00_1001, 6'b00_1001, 6'b00_1001, 6'b00_1001,
          6'b00_0000, 6'b00_0000};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      Req = v[i][5:4];
      tick();
      n_vec++;
      if ({Gate_EN, Grant, Busy} !== v[i][3:0]) begin
        n_err++;
        $display("FAIL wake_withdraw step %0d: got %b expected %b", i + 1,
                 {Gate_EN, Grant, Busy}, v[i][3:0]);
      end
    end
  endtask

  // Rows are {RST, Req, expected obs}.
  task automatic test_reset_mid();
    logic [6:0] v [7];
    v = '{7'b1_10_1001, 7'b1_10_1001, 7'b1_10_1101, 7'b0_10_0000, 7'b1_11_1001,
          7'b1_11_1001, 7'b1_11_1011};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      RST = v[i][6];
      Req = v[i][5:4];
      if (i == 3) begin
        #1;
        n_vec++;
        if ({Gate_EN, Grant, Busy} !== 4'b1101) begin
          n_err++;
          $display("FAIL reset_sync_hold: got %b expected %b", {Gate_EN, Grant, Busy},
                   4'b1101);
        end
      end
      tick();
      n_vec++;
      if ({Gate_EN, Grant, Busy} !== v[i][3:0]) begin
        n_err++;
        $display("FAIL reset_mid step %0d: got %b expected %b", i + 1,
                 {Gate_EN, Grant, Busy}, v[i][3:0]);
      end
    end
  endtask

  task automatic test_scan_mode();
    do_reset();
    tick();
    Test_Mode = 1'b1;
    #1;
    n_vec++;
    if ({Gate_EN, Grant, Busy} !== 4'b1000) begin
      n_err++;
      $display("FAIL scan_on: got %b expected %b", {Gate_EN, Grant, Busy}, 4'b1000);
    end
    tick();
    n_vec++;
    if ({Gate_EN, Grant, Busy} !== 4'b1000) begin
      n_err++;
      $display("FAIL scan_hold: got %b expected %b", {Gate_EN, Grant, Busy}, 4'b1000);
    end
    Test_Mode = 1'b0;
    #1;
    n_vec++;
    if ({Gate_EN, Grant, Busy} !== 4'b0000) begin
      n_err++;
      $display("FAIL scan_off: got %b expected %b", {Gate_EN, Grant, Busy}, 4'b0000);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_late_idle();
    test_wake_withdraw();
    test_reset_mid();
    test_scan_mode();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
